data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/dm_pkg.sv | 14 +
 rtl/dm_sram_array.sv | 28 ++
 rtl/data_memory.sv | 100 ++++++++++
 tb/tb_data_memory.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and helpers for the data memory: FSM state encoding and strobe width.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_t;

  function automatic int strb_w(input int xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/dm_sram_array.sv
// Byte-write synchronous RAM; read data registers only when re is high, no reset on contents.
module dm_sram_array
  import dm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter int SW    = strb_w(XLEN)
) (
  input  logic            clk,
  input  logic            we,
  input  logic            re,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [SW-1:0]   wstrb,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < SW; b++) begin
      if (we && wstrb[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory with request/ready handshake, programmable wait states and range checks.
// Define DATA_MEMORY_ALIGN_CHECK_EN to flag addresses with nonzero [1:0] as errors.
module data_memory
  import dm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_dm_req,
  output logic                  o_dm_ready,
  input  logic [XLEN-1:0]       i_dm_addr,
  input  logic                  i_dm_wvalid,
  input  logic [XLEN-1:0]       i_dm_wdata,
  input  logic [XLEN/8-1:0]     i_dm_wstrb,
  output logic                  o_dm_rvalid,
  output logic [XLEN-1:0]       o_dm_rdata,
  output logic                  o_dm_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = strb_w(XLEN);
  localparam logic [XLEN-1:0] ADDR_MASK = XLEN'(DEPTH * 4 - 1);
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  dm_state_t       state;
  logic [3:0]      cnt;
  logic            err_pend;
  logic            rd_ok;
  logic [XLEN-1:0] ram_q;
  logic            oor, misal, bad, accept;

  assign oor = |(i_dm_addr & ~ADDR_MASK);
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
  assign misal = |i_dm_addr[1:0];
`else
  assign misal = 1'b0;
`endif
  assign bad    = oor | misal;
  assign accept = i_dm_req & o_dm_ready;

  dm_sram_array #(.XLEN(XLEN), .DEPTH(DEPTH)) u_ram (
    .clk   (i_clk),
    .we    (accept & i_dm_wvalid & ~bad),
    .re    (accept & ~i_dm_wvalid & ~bad),
    .addr  (i_dm_addr[AW+1:2]),
    .wdata (i_dm_wdata),
    .wstrb (i_dm_wstrb[SW-1:0]),
    .rdata (ram_q)
  );

  // RAM output holds the word captured at accept; rd_ok gates it to zero for writes, errors and after reset.
  assign o_dm_rdata = rd_ok ? ram_q : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      err_pend    <= 1'b0;
      rd_ok       <= 1'b0;
      o_dm_ready  <= 1'b1;
      o_dm_rvalid <= 1'b0;
      o_dm_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt        <= '0;
          err_pend   <= bad;
          rd_ok      <= ~i_dm_wvalid & ~bad;
          o_dm_ready <= 1'b0;
          if (WAIT_CYCLES == 0) begin
            state       <= RESP;
            o_dm_rvalid <= 1'b1;
            o_dm_err    <= bad;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (cnt == CNT_LAST) begin
            state       <= RESP;
            o_dm_rvalid <= 1'b1;
            o_dm_err    <= err_pend;
          end
        end
        RESP: begin
          state       <= IDLE;
          o_dm_rvalid <= 1'b0;
          o_dm_err    <= 1'b0;
          o_dm_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench: a zero-wait instance driven from a vector table, plus a 3-wait instance for timing and reset cases.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, sel, wvalid;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;

  logic        ready0, rvalid0, err0, ready3, rvalid3, err3;
  logic [31:0] rdata0, rdata3;
  logic        ready, rvalid, err;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign ready  = sel ? ready3  : ready0;
  assign rvalid = sel ? rvalid3 : rvalid0;
  assign rdata  = sel ? rdata3  : rdata0;
  assign err    = sel ? err3    : err0;

  data_memory #(.XLEN(32), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_dm_req(req & ~sel), .o_dm_ready(ready0),
    .i_dm_addr(addr), .i_dm_wvalid(wvalid), .i_dm_wdata(wdata), .i_dm_wstrb(wstrb),
    .o_dm_rvalid(rvalid0), .o_dm_rdata(rdata0), .o_dm_err(err0));

  data_memory #(.XLEN(32), .DEPTH(1024), .WAIT_CYCLES(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_dm_req(req & sel), .o_dm_ready(ready3),
    .i_dm_addr(addr), .i_dm_wvalid(wvalid), .i_dm_wdata(wdata), .i_dm_wstrb(wstrb),
    .o_dm_rvalid(rvalid3), .o_dm_rdata(rdata3), .o_dm_err(err3));

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] er, input logic ee);
    vec_t v;
    v.wr = w; v.addr = a; v.wdata = d; v.wstrb = s; v.exp_rdata = er; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  // One full access: present, wait for ready, measure accept->rvalid latency, confirm a one-cycle pulse.
  task automatic access(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] st, input int exp_lat,
                        output logic [31:0] rd, output logic er);
    int n, lat;
    @(negedge clk);
    sel = s; req = 1'b1; wvalid = w; addr = a; wdata = d; wstrb = st;
    n = 0;
    while (!ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_before_accept", 32'(ready), 32'd1);
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    while (!rvalid && lat < 40) begin @(negedge clk); lat++; end
    chk("latency", lat, exp_lat);
    rd = rdata; er = err;
    @(negedge clk);
    chk("rvalid_one_cycle", 32'(rvalid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cnt;

    rst_n = 1'b0; req = 1'b0; sel = 1'b0; wvalid = 1'b0;
    addr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready0", 32'(ready0), 32'd1);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_ready3", 32'(ready3), 32'd1);
    chk("rst_rvalid3", 32'(rvalid3), 32'd0);

    add(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    add(0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 0);
    add(1, 32'h10, 32'h11223344, 4'h5, 32'h0, 0);
    add(0, 32'h10, 32'h0,        4'h0, 32'hDE22BE44, 0);
    add(1, 32'h0,  32'hA5A5A5A5, 4'hF, 32'h0, 0);
    add(1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    add(0, 32'h0,  32'h0,        4'h0, 32'hA5A5A5A5, 0);
    add(0, 32'h1000, 32'h0,      4'h0, 32'h0, 1);
    add(1, 32'h14, 32'h12345678, 4'hF, 32'h0, 0);
    add(1, 32'h14, 32'h00000000, 4'h0, 32'h0, 0);
    add(0, 32'h14, 32'h0,        4'h0, 32'h12345678, 0);
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
    add(0, 32'h12, 32'h0,        4'h0, 32'h0, 1);
    add(1, 32'h11, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
`else
    add(0, 32'h12, 32'h0,        4'h0, 32'hDE22BE44, 0);
    add(1, 32'h11, 32'h99999999, 4'h0, 32'h0, 0);
`endif
    add(0, 32'h10, 32'h0,        4'h0, 32'hDE22BE44, 0);
    add(1, 32'h80000010, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    add(0, 32'h10, 32'h0,        4'h0, 32'hDE22BE44, 0);
    add(1, 32'hFFC, 32'h0BADF00D, 4'hF, 32'h0, 0);
    add(0, 32'hFFC, 32'h0,       4'h0, 32'h0BADF00D, 0);

    foreach (vecs[i]) begin
      access(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 1, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Wait-state timing with a request held through the busy window.
    access(1'b1, 1'b1, 32'h10, 32'h01020304, 4'hF, 4, rd, er);
    access(1'b1, 1'b1, 32'h20, 32'h55AA1234, 4'hF, 4, rd, er);
    @(negedge clk);
    sel = 1'b1; req = 1'b1; wvalid = 1'b0; addr = 32'h10;
    chk("w3_idle_ready", 32'(ready), 32'd1);
    @(negedge clk);
    addr = 32'h20;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("w3_ready_low_t%0d", k), 32'(ready), 32'd0);
      chk($sformatf("w3_rvalid_t%0d", k), 32'(rvalid), 32'(k == 4));
      if (k == 4) chk("w3_rdata_first", rdata, 32'h01020304);
      @(negedge clk);
    end
    chk("w3_ready_t5", 32'(ready), 32'd1);
    @(negedge clk);
    chk("w3_held_accepted", 32'(ready), 32'd0);
    req = 1'b0;
    cnt = 1;
    while (!rvalid && cnt < 40) begin @(negedge clk); cnt++; end
    chk("w3_second_latency", cnt, 4);
    chk("w3_rdata_second", rdata, 32'h55AA1234);

    // Reset during WAIT drops the response; earlier write survives.
    access(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 4, rd, er);
    @(negedge clk);
    sel = 1'b1; req = 1'b1; wvalid = 1'b0; addr = 32'h40;
    @(negedge clk);
    req = 1'b0;
    chk("rst_mid_in_wait", 32'(ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready_async", 32'(ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rvalid) cnt++;
    end
    chk("rst_mid_no_rvalid", cnt, 0);
    chk("rst_mid_rdata_zero", rdata, 32'd0);
    access(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 4, rd, er);
    chk("rst_persist_rdata", rd, 32'hCAFEF00D);
    chk("rst_persist_err", 32'(er), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
